peripheral_control_logic_multi: RTL and testbench
=================================================

Name: peripheral_control_logic_multi

Overview:
- Parametrised successor to the single-child peripheral control node.
- Arbitrates NUM_CHILDREN child request lines onto one parent power/clock-domain request, and drives one enable_req/enable_ack handshake to the peripheral.
- Adds three behaviours the single-child node lacks: a configurable idle hold-off before stopping, an acknowledge timeout with a sticky fault state, and per-child ready gating.

Parameters:
- NUM_CHILDREN, 4: number of child request channels (≥1).
- HOLD_CYCLES, 2: consecutive cycles with no child request, while STARTED, before the stop sequence begins. 0 means stop on the first idle cycle.
- ACK_TIMEOUT, 255: cycles allowed in STARTING or STOPPING before entering FAULT. 0 disables the timeout.

Ports:
- clock  in  1  system clock
- async_resetn  in  1  asynchronous active-low reset
- parent_request  out  1  request to parent node
- parent_ready  in  1  parent domain ready
- parent_silent  in  1  parent domain silent
- parent_starting  in  1  parent starting (informational, unused in transitions)
- parent_stopping  in  1  parent stopping
- child_request  in  NUM_CHILDREN  per-child request
- child_ready  out  NUM_CHILDREN  per-child ready
- child_silent  out  1  node silent
- child_starting  out  1  node starting
- child_stopping  out  1  node stopping
- enable_req  out  1  peripheral enable request (registered)
- enable_ack  in  1  peripheral enable acknowledge
- fault  out  1  handshake timeout occurred (sticky)
- fault_clear  in  1  single-cycle pulse to leave FAULT

Behaviour:
- One clock; reset is asynchronous and active-low on async_resetn.
- Reset state: STOPPED. enable_req=0, fault=0, idle and timeout counters 0.
- any_req = OR of child_request.
- go = any_req & parent_ready & ~parent_stopping.
- State machine (registered state; outputs decoded from state unless stated otherwise):
  - STOPPED: enable_req=0. If go → STARTING; enable_req becomes 1 on that same clock edge.
  - STARTING: enable_req=1.
    - enable_ack=1 → STARTED.
    - If ACK_TIMEOUT≠0 and the timeout counter reaches ACK_TIMEOUT → FAULT.
    - parent_stopping, or loss of any_req, does not abort the start; the node still waits for enable_ack.
  - STARTED: enable_req=1.
    - Idle counter increments each cycle that any_req=0 and clears on any cycle that any_req=1.
    - Go to STOPPING when idle counter == HOLD_CYCLES with any_req=0, or when parent_stopping=1 (immediate).
  - STOPPING: enable_req=0.
    - enable_ack=0 → STOPPED.
    - Timeout → FAULT, as in STARTING.
    - A new request during STOPPING does not abort; the stop completes, then STOPPED re-evaluates go on the following cycle.
  - FAULT: enable_req=0, fault=1.
    - If fault_clear=1 and enable_ack=0 → STOPPED; fault deasserts on the same edge.
    - fault_clear with enable_ack=1 is ignored.
- Timeout counter:
  - width $clog2(ACK_TIMEOUT+1);
  - clears on every state change;
  - increments each cycle in STARTING or STOPPING;
  - saturates and does not wrap.
- Idle counter:
  - width $clog2(HOLD_CYCLES+1);
  - clears on leaving STARTED;
  - saturates.
- Output decode:
  - parent_request = any_req | STARTING | STOPPING.
  - child_ready[i] = child_request[i] & parent_ready & STARTED.
  - child_silent = parent_silent | STOPPED | FAULT.
  - child_starting = STARTING; child_stopping = STOPPING.
- Latency:
  - request to enable_req = 1 cycle;
  - enable_ack to child_ready = 1 cycle.
- Simultaneous events: in STARTED, parent_stopping takes priority over the idle count.
- Reset mid-handshake returns the node to STOPPED with enable_req=0 immediately (asynchronous), regardless of enable_ack.

Test Plan:
- Basic start/stop (NUM_CHILDREN=4, HOLD=2):
  - stimulus: parent_ready=1, child_request=4'b0010 held; ack returns 3 cycles after enable_req.
  - required: enable_req=1 one cycle after the request; child_ready=4'b0010 one cycle after ack.
  - then drop the request: enable_req falls after 3 idle cycles; ack drops; state returns to STOPPED with child_silent=1.
- Hold-off retrigger:
  - stimulus: in STARTED, request low for 2 cycles, then high 1 cycle, then low.
  - required: no stop during the blip; the stop begins only after HOLD_CYCLES+1 fresh idle cycles.
- Start timeout (ACK_TIMEOUT=8):
  - stimulus: never assert enable_ack.
  - required: fault=1 and enable_req=0 exactly 9 cycles after entering STARTING.
  - then pulse fault_clear with ack=0: back to STOPPED, fault=0.
- Parent stopping:
  - stimulus: in STARTED with child_request=4'b1111, assert parent_stopping.
  - required: STOPPING on the next cycle; child_ready=0; child_stopping=1.
  - with parent_stopping still high, STOPPED must not restart.
- Request during STOPPING:
  - stimulus: child request rises while enable_ack is still 1.
  - required: enable_req stays 0 until ack=0 and STOPPED is reached, then re-asserts one cycle later.
- Async reset mid-STARTING:
  - stimulus: assert async_resetn=0 while in STARTING.
  - required: enable_req=0, fault=0, parent_request equal to any_req only, with no clock edge needed.

Source files
------------

// File: rtl/peripheral_control_logic_multi.sv
// Power/clock-domain control node: merges NUM_CHILDREN child requests into one parent
// request and runs the enable_req/enable_ack handshake with idle hold-off and ack timeout.
module peripheral_control_logic_multi #(
  parameter int unsigned NUM_CHILDREN = 4,
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic                    clock,
  input  logic                    async_resetn,
  output logic                    parent_request,
  input  logic                    parent_ready,
  input  logic                    parent_silent,
  input  logic                    parent_starting,
  input  logic                    parent_stopping,
  input  logic [NUM_CHILDREN-1:0] child_request,
  output logic [NUM_CHILDREN-1:0] child_ready,
  output logic                    child_silent,
  output logic                    child_starting,
  output logic                    child_stopping,
  output logic                    enable_req,
  input  logic                    enable_ack,
  output logic                    fault,
  input  logic                    fault_clear
);

  localparam int unsigned IDLE_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int unsigned TO_W   = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(HOLD_CYCLES);
  localparam logic [TO_W-1:0]   TO_LIMIT   = TO_W'(ACK_TIMEOUT);
  localparam bit                TO_EN      = (ACK_TIMEOUT != 0);

  typedef enum logic [2:0] {
    ST_STOPPED,
    ST_STARTING,
    ST_STARTED,
    ST_STOPPING,
    ST_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              enable_req_q, enable_req_d;
  logic              fault_q, fault_d;
  logic              any_req;
  logic              go;
  logic              timed_out;

  // parent_starting is informational only
  logic unused_parent_starting;
  assign unused_parent_starting = parent_starting;

  // Next-state, counters and registered-output next values
  always_comb begin
    any_req      = |child_request;
    go           = any_req & parent_ready & ~parent_stopping;
    timed_out    = TO_EN && (to_q == TO_LIMIT);
    state_d      = state_q;
    idle_d       = idle_q;
    to_d         = to_q;
    enable_req_d = 1'b0;
    fault_d      = 1'b0;

    case (state_q)
      ST_STOPPED: begin
        if (go) state_d = ST_STARTING;
      end
      ST_STARTING: begin
        if (enable_ack)     state_d = ST_STARTED;
        else if (timed_out) state_d = ST_FAULT;
      end
      ST_STARTED: begin
        // parent_stopping wins over the idle hold-off
        if (parent_stopping)                           state_d = ST_STOPPING;
        else if (!any_req && (idle_q == IDLE_LIMIT))   state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (!enable_ack)    state_d = ST_STOPPED;
        else if (timed_out) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (fault_clear && !enable_ack) state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase

    if (state_d != state_q) begin
      to_d = '0;
    end else if (((state_q == ST_STARTING) || (state_q == ST_STOPPING)) && (to_q != TO_LIMIT)) begin
      to_d = to_q + TO_W'(1);
    end

    // Idle run only counts while staying in STARTED
    if ((state_q != ST_STARTED) || (state_d != ST_STARTED) || any_req) begin
      idle_d = '0;
    end else if (idle_q != IDLE_LIMIT) begin
      idle_d = idle_q + IDLE_W'(1);
    end

    enable_req_d = (state_d == ST_STARTING) || (state_d == ST_STARTED);
    fault_d      = (state_d == ST_FAULT);
  end

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state_q      <= ST_STOPPED;
      idle_q       <= '0;
      to_q         <= '0;
      enable_req_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      to_q         <= to_d;
      enable_req_q <= enable_req_d;
      fault_q      <= fault_d;
    end
  end

  assign enable_req     = enable_req_q;
  assign fault          = fault_q;
  assign parent_request = (|child_request) | (state_q == ST_STARTING) | (state_q == ST_STOPPING);
  assign child_ready    = child_request & {NUM_CHILDREN{parent_ready && (state_q == ST_STARTED)}};
  assign child_silent   = parent_silent | (state_q == ST_STOPPED) | (state_q == ST_FAULT);
  assign child_starting = (state_q == ST_STARTING);
  assign child_stopping = (state_q == ST_STOPPING);

endmodule

// File: tb/tb_peripheral_control_logic_multi.sv
// Scoreboard bench for peripheral_control_logic_multi: directed scenarios then random traffic,
// expected outputs from a string-state reference model pushed to a queue and checked by a monitor.
module tb_peripheral_control_logic_multi;

  localparam int unsigned N    = 4;
  localparam int unsigned HOLD = 2;
  localparam int unsigned TOUT = 8;
  localparam int FOLLOW = 0;
  localparam int LOW    = 1;
  localparam int HIGH   = 2;

  logic         clock = 1'b0;
  logic         async_resetn;
  logic         parent_request;
  logic         parent_ready;
  logic         parent_silent;
  logic         parent_starting;
  logic         parent_stopping;
  logic [N-1:0] child_request;
  logic [N-1:0] child_ready;
  logic         child_silent;
  logic         child_starting;
  logic         child_stopping;
  logic         enable_req;
  logic         enable_ack;
  logic         fault;
  logic         fault_clear;

  peripheral_control_logic_multi #(
    .NUM_CHILDREN(N),
    .HOLD_CYCLES (HOLD),
    .ACK_TIMEOUT (TOUT)
  ) dut (
    .clock          (clock),
    .async_resetn   (async_resetn),
    .parent_request (parent_request),
    .parent_ready   (parent_ready),
    .parent_silent  (parent_silent),
    .parent_starting(parent_starting),
    .parent_stopping(parent_stopping),
    .child_request  (child_request),
    .child_ready    (child_ready),
    .child_silent   (child_silent),
    .child_starting (child_starting),
    .child_stopping (child_stopping),
    .enable_req     (enable_req),
    .enable_ack     (enable_ack),
    .fault          (fault),
    .fault_clear    (fault_clear)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    logic         en;
    logic         flt;
    logic         preq;
    logic [N-1:0] crdy;
    logic         silent;
    logic         starting;
    logic         stopping;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: node phase as a name, cycles spent in it, and current idle run
  string m_st    = "STOPPED";
  int    m_dwell = 0;
  int    m_idle  = 0;
  int    ack_delay = 3;
  int    ack_wait  = 0;

  function automatic bit m_en();
    return (m_st == "STARTING") || (m_st == "STARTED");
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_checks++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t (model %s)", nm, act, ex, $time, m_st);
    end
  endtask

  task automatic model_step(input logic [N-1:0] req, input bit pr, input bit pstop,
                            input bit fclr, input bit a);
    string nxt;
    bit    any;
    nxt = m_st;
    any = |req;
    if (m_st == "STOPPED") begin
      if (any && pr && !pstop) nxt = "STARTING";
    end else if (m_st == "STARTING") begin
      if (a) nxt = "STARTED";
      else if (m_dwell == int'(TOUT)) nxt = "FAULT";
    end else if (m_st == "STARTED") begin
      if (pstop || (!any && m_idle == int'(HOLD))) nxt = "STOPPING";
    end else if (m_st == "STOPPING") begin
      if (!a) nxt = "STOPPED";
      else if (m_dwell == int'(TOUT)) nxt = "FAULT";
    end else if (m_st == "FAULT") begin
      if (fclr && !a) nxt = "STOPPED";
    end
    if (nxt != m_st) begin
      m_st    = nxt;
      m_dwell = 0;
      m_idle  = 0;
    end else begin
      m_dwell++;
      if (m_st == "STARTED") m_idle = any ? 0 : m_idle + 1;
    end
  endtask

  // One clock: drive at negedge, push expectation, advance model at posedge
  task automatic cycle(input logic [N-1:0] req, input bit rst, input bit pr, input bit ps,
                       input bit pstop, input bit fclr, input int amode);
    exp_t e;
    @(negedge clock);
    async_resetn    = rst;
    child_request   = req;
    parent_ready    = pr;
    parent_silent   = ps;
    parent_stopping = pstop;
    fault_clear     = fclr;
    parent_starting = 1'($urandom_range(0, 1));
    if (!rst) begin
      m_st    = "STOPPED";
      m_dwell = 0;
      m_idle  = 0;
    end
    if (amode == LOW) begin
      enable_ack = 1'b0;
      ack_wait   = 0;
    end else if (amode == HIGH) begin
      enable_ack = 1'b1;
      ack_wait   = 0;
    end else if (enable_ack != m_en()) begin
      ack_wait++;
      if (ack_wait >= ack_delay) begin
        enable_ack = m_en();
        ack_wait   = 0;
      end
    end else begin
      ack_wait = 0;
    end
    e.en       = m_en();
    e.flt      = (m_st == "FAULT");
    e.preq     = (|req) || (m_st == "STARTING") || (m_st == "STOPPING");
    e.crdy     = ((m_st == "STARTED") && pr) ? req : '0;
    e.silent   = ps || (m_st == "STOPPED") || (m_st == "FAULT");
    e.starting = (m_st == "STARTING");
    e.stopping = (m_st == "STOPPING");
    exp_q.push_back(e);
    @(posedge clock);
    if (rst) model_step(req, pr, pstop, fclr, enable_ack);
  endtask

  task automatic rep(input int n, input logic [N-1:0] req, input bit pstop, input bit fclr,
                     input int amode);
    for (int i = 0; i < n; i++) cycle(req, 1'b1, 1'b1, 1'b0, pstop, fclr, amode);
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("enable_req",     32'(enable_req),     32'(e.en));
        chk("fault",          32'(fault),          32'(e.flt));
        chk("parent_request", 32'(parent_request), 32'(e.preq));
        chk("child_ready",    32'(child_ready),    32'(e.crdy));
        chk("child_silent",   32'(child_silent),   32'(e.silent));
        chk("child_starting", 32'(child_starting), 32'(e.starting));
        chk("child_stopping", 32'(child_stopping), 32'(e.stopping));
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    int           am;
    async_resetn    = 1'b0;
    child_request   = '0;
    parent_ready    = 1'b0;
    parent_silent   = 1'b0;
    parent_starting = 1'b0;
    parent_stopping = 1'b0;
    fault_clear     = 1'b0;
    enable_ack      = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, LOW);

    // Basic start/stop with ack 3 cycles behind enable_req
    ack_delay = 3;
    rep(12, 4'b0010, 0, 0, FOLLOW);
    rep(12, 4'b0000, 0, 0, FOLLOW);

    // Hold-off retrigger
    rep(10, 4'b0100, 0, 0, FOLLOW);
    rep(2,  4'b0000, 0, 0, FOLLOW);
    rep(1,  4'b0100, 0, 0, FOLLOW);
    rep(12, 4'b0000, 0, 0, FOLLOW);

    // Start timeout, then clear
    rep(14, 4'b0001, 0, 0, LOW);
    rep(1,  4'b0000, 0, 1, LOW);
    rep(3,  4'b0000, 0, 0, LOW);

    // Stop timeout, clear ignored while ack high, then cleared
    rep(8,  4'b1000, 0, 0, FOLLOW);
    rep(14, 4'b0000, 0, 0, HIGH);
    rep(1,  4'b0000, 0, 1, HIGH);
    rep(2,  4'b0000, 0, 0, HIGH);
    rep(1,  4'b0000, 0, 1, LOW);
    rep(3,  4'b0000, 0, 0, LOW);

    // Parent stopping while STARTED; no restart while it stays high
    rep(8,  4'b1111, 0, 0, FOLLOW);
    rep(10, 4'b1111, 1, 0, FOLLOW);
    rep(8,  4'b1111, 0, 0, FOLLOW);
    rep(10, 4'b0000, 0, 0, FOLLOW);

    // Request arriving during STOPPING
    rep(8,  4'b0010, 0, 0, FOLLOW);
    rep(3,  4'b0000, 0, 0, FOLLOW);
    rep(8,  4'b0100, 0, 0, FOLLOW);
    rep(10, 4'b0000, 0, 0, FOLLOW);

    // Async reset while STARTING
    rep(3, 4'b0001, 0, 0, LOW);
    cycle(4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, LOW);
    cycle(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, LOW);
    rep(4, 4'b0000, 0, 0, FOLLOW);

    // Random traffic in chunks with varying ack behaviour
    rq = '0;
    for (int c = 0; c < 30; c++) begin
      ack_delay = int'($urandom_range(1, 5));
      am = ($urandom_range(0, 9) < 7) ? FOLLOW : int'($urandom_range(1, 2));
      for (int i = 0; i < 20; i++) begin
        if ($urandom_range(0, 3) == 0) rq = N'($urandom);
        cycle(rq, ($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 5) == 0), am);
      end
    end
    rep(12, 4'b0000, 0, 1, LOW);

    @(negedge clock);
    #5;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
